instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-memory interface.
- Owns the program counter and drives the word address to the combinational instruction memory (128 words; address bits [8:2] index it).
- Captures the returned word into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles stall, branch/jump redirect with flush, and halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 128: instruction memory depth in words, used only for the out-of-range flag.

Ports:
- Clk  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ImemAddress  output  32  byte address to instruction memory; equals the PC register.
- ImemInstruction  input  32  combinational read data for ImemAddress.
- Redirect  input  1  branch/jump taken; load a new PC and flush.
- RedirectTarget  input  32  new PC; bits [1:0] ignored.
- Halt  input  1  stop fetching after the current cycle.
- OutReady  input  1  decode accepts OutInstruction this cycle.
- OutValid  output  1  IF/ID register holds a live instruction.
- OutInstruction  output  32  fetched instruction word.
- OutPC  output  32  address of OutInstruction.
- OutPCPlus4  output  32  OutPC + 4 (mod 2^32), for link and branch base.
- OutOfRange  output  1  OutPC word index >= IMEM_WORDS.

Behaviour:
- Reset (asynchronous, active-high):
  - PC = RESET_PC; state = START.
  - OutValid = 0; OutInstruction = 0; OutPC = 0; OutPCPlus4 = 0; OutOfRange = 0.
- ImemAddress = PC, combinational from the register. Memory read has zero latency, so ImemInstruction is sampled on the same edge.
- FSM states: START, FETCH, HALTED.
  - START: one bubble cycle after reset deassertion, OutValid stays 0. Goes to FETCH next edge. A Redirect here is honoured: PC is loaded, still goes to FETCH.
  - FETCH, define load = (!OutValid || OutReady):
    - load: IF/ID <= {ImemInstruction, PC, PC+4}; OutValid <= 1; PC <= PC+4.
    - !load (OutValid && !OutReady): PC and IF/ID hold unchanged. This is the stall.
  - HALTED: PC frozen, no new fetch. OutValid clears on the edge where OutReady=1. Leaves only via Redirect, to FETCH.
- Priority per edge: Reset > Redirect > Halt > normal fetch/stall.
- Redirect, any state:
  - PC <= {RedirectTarget[31:2], 2'b00}; OutValid <= 0 (flush, even if stalled or OutReady=0).
  - Next state FETCH. The first redirected instruction has OutValid=1 one edge later.
- Halt in FETCH without Redirect:
  - If load, the current word is still captured.
  - Next state HALTED.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.
- OutOfRange = (OutPC[31:2] >= IMEM_WORDS), registered with OutPC. Fetch continues; the flag is informational.
- Decode sees exactly one OutValid per accepted word. No word is duplicated or dropped across a stall.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: adds output FetchCount (32 bits), reset to 0. Increments on each edge where OutValid && OutReady && !Redirect. Wraps modulo 2^32.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding typedef: START=2'd0, FETCH=2'd1, HALTED=2'd2.
  - Constants INSTR_WIDTH=32, PC_STEP=4.
  - RESET_PC default.
- One natural sub-module: if_id_register, holding the valid/instruction/PC/PC+4 register with load/flush/hold controls. The FSM and PC live in the top.

Test Plan:
- Reset, then OutReady=1 held, memory word i = i*3:
  - Cycle 1 after reset: OutValid=0.
  - Following edges: OutPC = 0, 4, 8 with OutInstruction = 0, 3, 6.
  - OutPCPlus4 = 4, 8, 12.
- Stall: at OutPC=8 drop OutReady for 3 cycles:
  - OutInstruction=6 and ImemAddress=12 hold.
  - On OutReady=1, the next word is OutPC=12, instruction 9. No skip, no repeat.
- Redirect during stall: OutValid=1, OutReady=0, Redirect=1, target 32'h0000_0043:
  - Next edge OutValid=0, ImemAddress=32'h40.
  - Following edge OutPC=32'h40, OutInstruction=48.
- Halt then Redirect:
  - Halt at PC=16: word 16 is captured, PC frozen at 20, no further valid after consumption.
  - Redirect to 0 resumes with OutPC=0.
- Wrap and range: Redirect to 32'hFFFF_FFFC:
  - OutOfRange=1, next ImemAddress=0, OutPCPlus4=0.
  - Redirect to 32'h200 gives OutOfRange=1; 32'h1FC gives 0.
- Async reset mid-stall: assert Reset between edges while OutValid=1:
  - OutValid=0 and ImemAddress=RESET_PC immediately, without waiting for Clk.
  - With FETCH_COUNT_EN, FetchCount=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// fetch constants, the IF/ID payload layout and the word-alignment helper.
// No ports; imported by instruction_fetch_unit and its IF/ID register.
package instruction_fetch_unit_pkg;

   localparam int          INSTR_WIDTH        = 32;
   localparam logic [31:0] PC_STEP            = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam int          DEFAULT_IMEM_WORDS = 128;

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   // Contents of the IF/ID pipeline register (valid bit kept separately).
   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [31:0]            pc;
      logic [31:0]            pc_plus4;
      logic                   out_of_range;
   } ifid_t;

   // Clears the byte-offset bits so every PC is word aligned.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~(PC_STEP - 32'd1);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds valid + {instruction, PC, PC+4, out-of-range}.
// Latency: one edge from load to output. Backpressure: holds when neither
// load nor clear is asserted; clear (flush/consume) beats load.
// Ports: clk/rst (async active-high), load, clear, in_* payload, valid, out_* payload.
module instruction_fetch_unit_if_id_register
   import instruction_fetch_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   clear,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [31:0]            in_pc,
   input  logic [31:0]            in_pc_plus4,
   input  logic                   in_out_of_range,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [31:0]            out_pc,
   output logic [31:0]            out_pc_plus4,
   output logic                   out_out_of_range
);

   ifid_t held;

   // A clear only drops the valid bit; the payload is left as-is since
   // nothing downstream looks at it while valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         held  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid             <= 1'b1;
         held.instr        <= in_instr;
         held.pc           <= in_pc;
         held.pc_plus4     <= in_pc_plus4;
         held.out_of_range <= in_out_of_range;
      end
   end

   assign out_instr        = held.instr;
   assign out_pc           = held.pc;
   assign out_pc_plus4     = held.pc_plus4;
   assign out_out_of_range = held.out_of_range;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a zero-latency instruction
// memory and feeds decode through the IF/ID register with valid/ready.
// Latency: word at PC appears on Out* one edge after it is addressed.
// Backpressure: OutValid && !OutReady freezes PC and IF/ID (no drop/repeat).
// Ports: Clk, Reset (async active-high), ImemAddress/ImemInstruction memory
// side, Redirect/RedirectTarget/Halt control, OutValid/OutReady handshake,
// OutInstruction/OutPC/OutPCPlus4/OutOfRange payload.
// Optional macro FETCH_COUNT_EN adds FetchCount, a count of accepted words.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
)
(
   input  logic                   Clk,
   input  logic                   Reset,
   output logic [31:0]            ImemAddress,
   input  logic [INSTR_WIDTH-1:0] ImemInstruction,
   input  logic                   Redirect,
   input  logic [31:0]            RedirectTarget,
   input  logic                   Halt,
   input  logic                   OutReady,
   output logic                   OutValid,
   output logic [INSTR_WIDTH-1:0] OutInstruction,
   output logic [31:0]            OutPC,
   output logic [31:0]            OutPCPlus4,
   output logic                   OutOfRange
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0]            FetchCount
`endif
);

   localparam logic [31:0] IMEM_WORDS_U = 32'(IMEM_WORDS);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus4;
   logic         oor_now;
   logic         can_load;
   logic         ifid_load;
   logic         ifid_clear;

   assign ImemAddress = pc;
   assign pc_plus4    = pc + PC_STEP;           // wraps modulo 2^32
   assign oor_now     = ({2'b00, pc[31:2]} >= IMEM_WORDS_U);
   // IF/ID can take a new word when it is empty or being drained this edge.
   assign can_load    = !OutValid || OutReady;

   // ------------------------------------------------------------------
   // State and PC registers
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_START;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state, next PC and IF/ID controls.
   // Redirect overrides everything else in every state; Halt comes next.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      pc_next    = pc;
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;

      if (Redirect) begin
         // Flush even while stalled: the held word is on the wrong path.
         pc_next    = align_word(RedirectTarget);
         ifid_clear = 1'b1;
         state_next = ST_FETCH;
      end else begin
         case (state)
            ST_START: begin
               // Bubble cycle out of reset; nothing is captured yet.
               state_next = Halt ? ST_HALTED : ST_FETCH;
            end
            ST_FETCH: begin
               if (can_load) begin
                  ifid_load = 1'b1;
                  pc_next   = pc_plus4;
               end
               // A halting cycle still captures the current word if it can.
               if (Halt) begin
                  state_next = ST_HALTED;
               end
            end
            ST_HALTED: begin
               // PC frozen; only let decode drain the last held word.
               if (OutReady) begin
                  ifid_clear = 1'b1;
               end
            end
            default: begin
               state_next = ST_START;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // IF/ID pipeline register
   // ------------------------------------------------------------------
   instruction_fetch_unit_if_id_register u_if_id (
      .clk              (Clk),
      .rst              (Reset),
      .load             (ifid_load),
      .clear            (ifid_clear),
      .in_instr         (ImemInstruction),
      .in_pc            (pc),
      .in_pc_plus4      (pc_plus4),
      .in_out_of_range  (oor_now),
      .valid            (OutValid),
      .out_instr        (OutInstruction),
      .out_pc           (OutPC),
      .out_pc_plus4     (OutPCPlus4),
      .out_out_of_range (OutOfRange)
   );

`ifdef FETCH_COUNT_EN
   // Counts words handed to decode; a word flushed by Redirect on the same
   // edge is not counted as accepted.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FetchCount <= '0;
      end else if (OutValid && OutReady && !Redirect) begin
         FetchCount <= FetchCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// asynchronous-reset sequence, then randomized traffic against a model.
module tb_instruction_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic        Halt;
   logic        OutReady;
   logic        OutValid;
   logic [31:0] OutInstruction;
   logic [31:0] OutPC;
   logic [31:0] OutPCPlus4;
   logic        OutOfRange;
`ifdef FETCH_COUNT_EN
   logic [31:0] FetchCount;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   // Memory word i holds i*3; address bits [8:2] select the word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {25'd0, a[8:2]} * 32'd3;
   endfunction

   assign ImemInstruction = mem_word(ImemAddress);

   instruction_fetch_unit dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .ImemAddress     (ImemAddress),
      .ImemInstruction (ImemInstruction),
      .Redirect        (Redirect),
      .RedirectTarget  (RedirectTarget),
      .Halt            (Halt),
      .OutReady        (OutReady),
      .OutValid        (OutValid),
      .OutInstruction  (OutInstruction),
      .OutPC           (OutPC),
      .OutPCPlus4      (OutPCPlus4),
      .OutOfRange      (OutOfRange)
`ifdef FETCH_COUNT_EN
      ,
      .FetchCount      (FetchCount)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] tgt;
      logic        halt;
      logic        e_valid;
      logic        e_data;   // compare payload only when set
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
      logic        e_oor;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rdy, input logic redir, input logic [31:0] tgt,
                              input logic halt, input logic e_valid, input logic e_data,
                              input logic [31:0] e_addr, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic [31:0] e_pc4,
                              input logic e_oor);
      vec_t r;
      r.rdy = rdy; r.redir = redir; r.tgt = tgt; r.halt = halt;
      r.e_valid = e_valid; r.e_data = e_data; r.e_addr = e_addr;
      r.e_instr = e_instr; r.e_pc = e_pc; r.e_pc4 = e_pc4; r.e_oor = e_oor;
      return r;
   endfunction

   // Behavioural reference for the random phase
   logic        m_bubble, m_halted, m_valid, m_oor;
   logic [31:0] m_pc, m_instr, m_opc, m_count;

   initial begin
      Reset = 1'b1; Redirect = 1'b0; RedirectTarget = '0; Halt = 1'b0; OutReady = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_valid", {31'd0, OutValid}, 32'd0);
      chk("rst_instr", OutInstruction, 32'd0);
      chk("rst_pc", OutPC, 32'd0);
      chk("rst_pc4", OutPCPlus4, 32'd0);
      chk("rst_oor", {31'd0, OutOfRange}, 32'd0);
      chk("rst_addr", ImemAddress, 32'd0);
`ifdef FETCH_COUNT_EN
      chk("rst_count", FetchCount, 32'd0);
`endif
      Reset = 1'b0;

      // ---------------- directed table ----------------
      //                rdy rd tgt           h  vld dat addr          instr pc            pc4           oor
      vecs.push_back(v(1, 0, 0,            0, 0, 0, 32'h0,        0,    0,            0,            0)); // START bubble
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h4,        0,    0,            4,            0));
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h8,        3,    4,            8,            0));
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0));
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0)); // stall x3
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0));
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0));
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h10,       9,    12,           16,           0));
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'h10,       9,    12,           16,           0));
      vecs.push_back(v(0, 1, 32'h43,       0, 0, 0, 32'h40,       0,    0,            0,            0)); // redirect in stall
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'h44,       48,   32'h40,       32'h44,       0));
      vecs.push_back(v(1, 1, 32'h10,       0, 0, 0, 32'h10,       0,    0,            0,            0));
      vecs.push_back(v(1, 0, 0,            1, 1, 1, 32'h14,       12,   16,           20,           0)); // halt
      vecs.push_back(v(1, 0, 0,            0, 0, 0, 32'h14,       0,    0,            0,            0));
      vecs.push_back(v(1, 0, 0,            0, 0, 0, 32'h14,       0,    0,            0,            0));
      vecs.push_back(v(0, 0, 0,            0, 0, 0, 32'h14,       0,    0,            0,            0));
      vecs.push_back(v(0, 1, 32'h0,        0, 0, 0, 32'h0,        0,    0,            0,            0)); // resume
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h4,        0,    0,            4,            0));
      vecs.push_back(v(1, 1, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 0,    0,            0,            0)); // wrap
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h0,        381,  32'hFFFFFFFC, 32'h0,        1));
      vecs.push_back(v(1, 1, 32'h200,      0, 0, 0, 32'h200,      0,    0,            0,            0));
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h204,      0,    32'h200,      32'h204,      1));
      vecs.push_back(v(1, 1, 32'h1FF,      0, 0, 0, 32'h1FC,      0,    0,            0,            0));
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'h200,      381,  32'h1FC,      32'h200,      0));
      vecs.push_back(v(1, 1, 32'h8,        1, 0, 0, 32'h8,        0,    0,            0,            0)); // redirect beats halt
      vecs.push_back(v(1, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0));
      vecs.push_back(v(0, 0, 0,            0, 1, 1, 32'hC,        6,    8,            12,           0));

      foreach (vecs[i]) begin
         OutReady = vecs[i].rdy; Redirect = vecs[i].redir;
         RedirectTarget = vecs[i].tgt; Halt = vecs[i].halt;
         @(posedge Clk);
         #1;
         chk($sformatf("vec%0d_valid", i), {31'd0, OutValid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d_addr", i), ImemAddress, vecs[i].e_addr);
         if (vecs[i].e_data) begin
            chk($sformatf("vec%0d_instr", i), OutInstruction, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc", i), OutPC, vecs[i].e_pc);
            chk($sformatf("vec%0d_pc4", i), OutPCPlus4, vecs[i].e_pc4);
            chk($sformatf("vec%0d_oor", i), {31'd0, OutOfRange}, {31'd0, vecs[i].e_oor});
         end
      end

      // ---------------- async reset mid-stall ----------------
      Redirect = 1'b0; Halt = 1'b0; OutReady = 1'b0;
      #3;
      Reset = 1'b1;
      #1;
      chk("arst_valid", {31'd0, OutValid}, 32'd0);
      chk("arst_addr", ImemAddress, 32'd0);
      chk("arst_pc", OutPC, 32'd0);
      chk("arst_instr", OutInstruction, 32'd0);
`ifdef FETCH_COUNT_EN
      chk("arst_count", FetchCount, 32'd0);
`endif

      // ---------------- randomized traffic vs model ----------------
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      m_bubble = 1'b1; m_halted = 1'b0; m_valid = 1'b0; m_oor = 1'b0;
      m_pc = 32'd0; m_instr = 32'd0; m_opc = 32'd0; m_count = 32'd0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         OutReady = ($urandom_range(0, 3) != 0);
         Redirect = ($urandom_range(0, 19) == 0);
         RedirectTarget = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 600);
         Halt = !m_bubble && ($urandom_range(0, 29) == 0);

         // model: what the edge must do given these inputs
         if (m_valid && OutReady && !Redirect) m_count = m_count + 32'd1;
         if (Redirect) begin
            m_pc = RedirectTarget & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_bubble = 1'b0; m_halted = 1'b0;
         end else if (m_bubble) begin
            m_bubble = 1'b0;
         end else if (m_halted) begin
            if (OutReady) m_valid = 1'b0;
         end else begin
            if (!m_valid || OutReady) begin
               m_instr = mem_word(m_pc);
               m_opc = m_pc;
               m_oor = ((m_pc >> 2) >= 32'd128);
               m_valid = 1'b1;
               m_pc = m_pc + 32'd4;
            end
            if (Halt) m_halted = 1'b1;
         end

         @(posedge Clk);
         #1;
         chk("rnd_valid", {31'd0, OutValid}, {31'd0, m_valid});
         chk("rnd_addr", ImemAddress, m_pc);
         if (m_valid) begin
            chk("rnd_instr", OutInstruction, m_instr);
            chk("rnd_pc", OutPC, m_opc);
            chk("rnd_pc4", OutPCPlus4, m_opc + 32'd4);
            chk("rnd_oor", {31'd0, OutOfRange}, {31'd0, m_oor});
         end
`ifdef FETCH_COUNT_EN
         chk("rnd_count", FetchCount, m_count);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
